// File: rtl/wash_sequencer.sv
// Wash-program sequencer: fill/wash, N rinse loops, drain/spin dry, pause/door interlock.
// Optional completion beeper is built only when WASH_BEEP_EN is defined.
module wash_sequencer #(
  parameter int unsigned TIME_W  = 8,
  parameter int unsigned LVL_W   = 3,
  parameter int unsigned FILL_T  = 2,
  parameter int unsigned DRAIN_T = 2,
  parameter int unsigned SPIN_T  = 3,
  parameter int unsigned BEEP_T  = 5
) (
  input  logic              clk,
  input  logic              resetBtn,
  input  logic              tick,
  input  logic              runBtn,
  input  logic              openBtn,
  input  logic [2:0]        mode,
  input  logic [1:0]        rinses,
  input  logic [LVL_W-1:0]  level,
  input  logic [TIME_W-1:0] wash_time,
  input  logic [TIME_W-1:0] rinse_time,
  output logic [3:0]        phase,
  output logic [TIME_W-1:0] remain,
  output logic [1:0]        rinse_idx,
  output logic              valve_in,
  output logic              valve_out,
  output logic              motor,
  output logic              running,
  output logic              paused,
  output logic              done,
  output logic              beep
);

  localparam int unsigned PW = LVL_W + 32;
  localparam logic [PW-1:0] TIME_MAX = PW'({TIME_W{1'b1}});

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FILL_W = 4'd1, S_WASH = 4'd2, S_DRAIN_R = 4'd3, S_SPIN_R = 4'd4,
    S_FILL_R = 4'd5, S_RINSE = 4'd6, S_DRAIN_D = 4'd7, S_SPIN_D = 4'd8, S_DONE = 4'd9,
    S_PAUSE = 4'd10
  } state_e;

  state_e            state_q, state_d, saved_q, saved_d;
  state_e            first_c, after_wash_c, after_rinse_c, adv_c;
  logic [TIME_W-1:0] remain_q, remain_d, wash_q, wash_d, rtime_q, rtime_d;
  logic [TIME_W-1:0] fill_c;
  logic [PW-1:0]     fill_prod_c;
  logic [1:0]        ridx_q, ridx_d, rinses_q, rinses_d;
  logic [2:0]        mode_q, mode_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              start_c, load_c, rinse_en_c, more_c;
  logic vin_q, vin_d, vout_q, vout_d, motor_q, motor_d;
  logic run_q, run_d, pause_q, pause_d, done_q, done_d;

  // Program configuration is captured on start and frozen until the next IDLE.
  always_comb begin
    start_c       = (state_q == S_IDLE) && runBtn && !openBtn && (mode != 3'd0);
    mode_d        = start_c ? mode       : mode_q;
    rinses_d      = start_c ? rinses     : rinses_q;
    level_d       = start_c ? level      : level_q;
    wash_d        = start_c ? wash_time  : wash_q;
    rtime_d       = start_c ? rinse_time : rtime_q;
    rinse_en_c    = mode_d[1] && (rinses_d != 2'd0);
    after_rinse_c = mode_d[2] ? S_DRAIN_D : S_DONE;
    after_wash_c  = rinse_en_c ? S_DRAIN_R : after_rinse_c;
    first_c       = mode_d[0] ? S_FILL_W : after_wash_c;
    fill_prod_c   = PW'(level_d) * PW'(FILL_T);
    fill_c        = (fill_prod_c > TIME_MAX) ? {TIME_W{1'b1}} : TIME_W'(fill_prod_c);
  end

  // Phase that follows the current one when its time runs out.
  always_comb begin
    more_c = ({1'b0, ridx_q} + 3'd1) < {1'b0, rinses_q};
    case (state_q)
      S_FILL_W:  adv_c = S_WASH;
      S_WASH:    adv_c = after_wash_c;
      S_DRAIN_R: adv_c = S_SPIN_R;
      S_SPIN_R:  adv_c = S_FILL_R;
      S_FILL_R:  adv_c = S_RINSE;
      S_RINSE:   adv_c = more_c ? S_DRAIN_R : after_rinse_c;
      S_DRAIN_D: adv_c = S_SPIN_D;
      S_SPIN_D:  adv_c = S_DONE;
      default:   adv_c = state_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    remain_d = remain_q;
    ridx_d   = ridx_q;
    load_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = first_c;
          ridx_d  = 2'd0;
          load_c  = 1'b1;
        end
      end
      S_PAUSE: begin
        if (runBtn && !openBtn) state_d = saved_q;
      end
      S_DONE: begin
        if (runBtn) begin
          state_d = S_IDLE;
          ridx_d  = 2'd0;
        end
      end
      S_FILL_W, S_WASH, S_DRAIN_R, S_SPIN_R, S_FILL_R, S_RINSE, S_DRAIN_D, S_SPIN_D: begin
        // Pause takes priority; a coincident tick is dropped.
        if (runBtn || openBtn) begin
          saved_d = state_q;
          state_d = S_PAUSE;
        end else if ((remain_q == '0) || (tick && (remain_q == TIME_W'(1)))) begin
          state_d = adv_c;
          load_c  = 1'b1;
          if ((state_q == S_RINSE) && (adv_c == S_DRAIN_R)) ridx_d = ridx_q + 2'd1;
        end else if (tick) begin
          remain_d = remain_q - TIME_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_c) begin
      case (state_d)
        S_FILL_W, S_FILL_R:   remain_d = fill_c;
        S_WASH:               remain_d = wash_d;
        S_RINSE:              remain_d = rtime_d;
        S_DRAIN_R, S_DRAIN_D: remain_d = TIME_W'(DRAIN_T);
        S_SPIN_R, S_SPIN_D:   remain_d = TIME_W'(SPIN_T);
        default:              remain_d = '0;
      endcase
    end
  end

  // Actuator/status decode of the upcoming phase, so outputs register with the state.
  always_comb begin
    vin_d   = (state_d == S_FILL_W) || (state_d == S_FILL_R);
    vout_d  = (state_d == S_DRAIN_R) || (state_d == S_DRAIN_D) ||
              (state_d == S_SPIN_R) || (state_d == S_SPIN_D);
    motor_d = (state_d == S_WASH) || (state_d == S_RINSE) ||
              (state_d == S_SPIN_R) || (state_d == S_SPIN_D);
    run_d   = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_PAUSE);
    pause_d = (state_d == S_PAUSE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (resetBtn) begin
      state_q  <= S_IDLE;
      saved_q  <= S_IDLE;
      remain_q <= '0;
      ridx_q   <= 2'd0;
      mode_q   <= 3'd0;
      rinses_q <= 2'd0;
      level_q  <= '0;
      wash_q   <= '0;
      rtime_q  <= '0;
      vin_q    <= 1'b0;
      vout_q   <= 1'b0;
      motor_q  <= 1'b0;
      run_q    <= 1'b0;
      pause_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      remain_q <= remain_d;
      ridx_q   <= ridx_d;
      mode_q   <= mode_d;
      rinses_q <= rinses_d;
      level_q  <= level_d;
      wash_q   <= wash_d;
      rtime_q  <= rtime_d;
      vin_q    <= vin_d;
      vout_q   <= vout_d;
      motor_q  <= motor_d;
      run_q    <= run_d;
      pause_q  <= pause_d;
      done_q   <= done_d;
    end
  end

`ifdef WASH_BEEP_EN
  localparam int unsigned BEEP_W = (BEEP_T > 1) ? $clog2(BEEP_T + 1) : 1;
  logic [BEEP_W-1:0] bcnt_q, bcnt_d;
  logic              beep_q, beep_d;

  // Beeper counts ticks from DONE entry; leaving DONE silences it at once.
  always_comb begin
    bcnt_d = bcnt_q;
    beep_d = beep_q;
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      bcnt_d = BEEP_W'(BEEP_T);
      beep_d = (BEEP_T != 0);
    end else if (state_d != S_DONE) begin
      bcnt_d = '0;
      beep_d = 1'b0;
    end else if (tick && (bcnt_q != '0)) begin
      bcnt_d = bcnt_q - BEEP_W'(1);
      beep_d = (bcnt_q != BEEP_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (resetBtn) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      beep_q <= beep_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

  assign phase     = state_q;
  assign remain    = remain_q;
  assign rinse_idx = ridx_q;
  assign valve_in  = vin_q;
  assign valve_out = vout_q;
  assign motor     = motor_q;
  assign running   = run_q;
  assign paused    = pause_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: vector table for pause/door, sequences for full cycle,
// zero durations, pause/tick collision, mid-phase reset and (WASH_BEEP_EN) the beeper.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       resetBtn, tick, runBtn, openBtn;
  logic [2:0] mode;
  logic [1:0] rinses;
  logic [2:0] level;
  logic [7:0] wash_time, rinse_time;
  logic [3:0] phase;
  logic [7:0] remain;
  logic [1:0] rinse_idx;
  logic       valve_in, valve_out, motor, running, paused, done, beep;

  int n_tests = 0;
  int n_fail  = 0;

  wash_sequencer dut (
    .clk(clk), .resetBtn(resetBtn), .tick(tick), .runBtn(runBtn), .openBtn(openBtn),
    .mode(mode), .rinses(rinses), .level(level), .wash_time(wash_time),
    .rinse_time(rinse_time), .phase(phase), .remain(remain), .rinse_idx(rinse_idx),
    .valve_in(valve_in), .valve_out(valve_out), .motor(motor), .running(running),
    .paused(paused), .done(done), .beep(beep)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic run;
    logic open;
    logic tk;
    int   ph;
    int   rem;
    logic mot;
    logic pau;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic o, input logic t, input int ph,
                              input int rem, input logic m, input logic p);
    vec_t v;
    v.run = r; v.open = o; v.tk = t; v.ph = ph; v.rem = rem; v.mot = m; v.pau = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    runBtn = 1'b1;
    step();
    runBtn = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic advance_to(input int ph, input int rem, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((int'(phase) == ph) && (int'(remain) == rem)) begin
        hit = 1'b1;
        break;
      end
      tick = (i % 2 == 0);
      step();
      tick = 1'b0;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  // {valve_in, valve_out, motor, running} expected in each phase
  function automatic logic [3:0] exp_act(input int ph);
    case (ph)
      1, 5:    return 4'b1001;
      2, 6:    return 4'b0011;
      3, 7:    return 4'b0101;
      4, 8:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    int   seq[$];
    int   exp_seq[13];
    int   ticks, max_idx, last;

    exp_seq = '{1, 2, 3, 4, 5, 6, 3, 4, 5, 6, 7, 8, 9};
    resetBtn = 1'b1; tick = 1'b0; runBtn = 1'b0; openBtn = 1'b0;
    mode = 3'd0; rinses = 2'd0; level = 3'd0; wash_time = 8'd0; rinse_time = 8'd0;
    step(); step();
    resetBtn = 1'b0;
    step();
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_remain", 32'(remain), 32'd0);
    check("reset_outs", 32'({rinse_idx, valve_in, valve_out, motor, running, paused, done, beep}), 32'd0);

    // mode 0 never starts
    pulse_run();
    check("mode0_nostart", 32'(phase), 32'd0);

    // Full program; inputs scrambled after start to prove they are latched.
    mode = 3'b111; rinses = 2'd2; level = 3'd2; wash_time = 8'd5; rinse_time = 8'd3;
    pulse_run();
    check("full_start_phase", 32'(phase), 32'd1);
    check("full_start_remain", 32'(remain), 32'd4);
    check("full_start_valve", 32'(valve_in), 32'd1);
    mode = 3'b000; rinses = 2'd0; level = 3'd7; wash_time = 8'd50; rinse_time = 8'd50;
    seq.push_back(int'(phase));
    last = int'(phase); ticks = 0; max_idx = 0;
    for (int c = 0; c < 2000 && phase != 4'd9; c++) begin
      tick = (c % 10 == 9);
      step();
      if (tick) ticks++;
      tick = 1'b0;
      if (int'(rinse_idx) > max_idx) max_idx = int'(rinse_idx);
      if (int'(phase) != last) begin
        seq.push_back(int'(phase));
        last = int'(phase);
        check($sformatf("full_act_ph%0d", last),
              32'({valve_in, valve_out, motor, running}), 32'(exp_act(last)));
      end
    end
    check("full_seq_len", 32'(seq.size()), 32'd13);
    for (int i = 0; i < 13; i++)
      check($sformatf("full_seq%0d", i), 32'((i < seq.size()) ? seq[i] : 15), 32'(exp_seq[i]));
    check("full_ticks", 32'(ticks), 32'd38);
    check("full_max_ridx", 32'(max_idx), 32'd1);
    check("full_done", 32'(done), 32'd1);
    pulse_run();
    check("full_ack_phase", 32'(phase), 32'd0);
    check("full_ack_ridx", 32'(rinse_idx), 32'd0);

    // Pause/door vectors: wash only, level 0, wash_time 5.
    mode = 3'b001; rinses = 2'd0; level = 3'd0; wash_time = 8'd5; rinse_time = 8'd0;
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 5, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 10, 3, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 10, 3, 0, 1));
    vecs.push_back(mk(1, 1, 0, 10, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 10, 3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) begin
      runBtn = vecs[i].run; openBtn = vecs[i].open; tick = vecs[i].tk;
      step();
      runBtn = 1'b0; tick = 1'b0;
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("vec%0d_remain", i), 32'(remain), 32'(vecs[i].rem));
      check($sformatf("vec%0d_motor", i), 32'(motor), 32'(vecs[i].mot));
      check($sformatf("vec%0d_paused", i), 32'(paused), 32'(vecs[i].pau));
    end
    openBtn = 1'b0;

    // runBtn and tick together in RINSE at remain 1: pause, no advance.
    mode = 3'b010; rinses = 2'd1; level = 3'd1; wash_time = 8'd0; rinse_time = 8'd2;
    pulse_run();
    check("simul_first_phase", 32'(phase), 32'd3);
    advance_to(6, 1, "simul_reach_rinse");
    runBtn = 1'b1; tick = 1'b1;
    step();
    runBtn = 1'b0; tick = 1'b0;
    check("simul_phase", 32'(phase), 32'd10);
    check("simul_remain", 32'(remain), 32'd1);
    step();
    check("simul_hold", 32'(phase), 32'd10);
    pulse_run();
    check("simul_resume_phase", 32'(phase), 32'd6);
    check("simul_resume_remain", 32'(remain), 32'd1);
    check("simul_ridx", 32'(rinse_idx), 32'd0);
    tick_pulse();
    check("simul_done", 32'(phase), 32'd9);
    pulse_run();

    // Reset in SPIN_R clears everything.
    mode = 3'b011; rinses = 2'd1; level = 3'd1; wash_time = 8'd1; rinse_time = 8'd1;
    pulse_run();
    advance_to(4, 3, "rst_reach_spin");
    resetBtn = 1'b1;
    step();
    resetBtn = 1'b0;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_remain", 32'(remain), 32'd0);
    check("rst_outs", 32'({rinse_idx, valve_in, valve_out, motor, running, paused, done, beep}), 32'd0);

    // Zero durations: FILL_W and WASH one clk each, DONE without any tick.
    mode = 3'b001; rinses = 2'd0; level = 3'd0; wash_time = 8'd0;
    pulse_run();
    check("zero_fill", 32'(phase), 32'd1);
    step();
    check("zero_wash", 32'(phase), 32'd2);
    check("zero_wash_motor", 32'(motor), 32'd1);
    step();
    check("zero_done", 32'(phase), 32'd9);
    check("zero_done_flag", 32'(done), 32'd1);

`ifdef WASH_BEEP_EN
    check("beep_on_entry", 32'(beep), 32'd1);
    tick_pulse(); tick_pulse();
    check("beep_after2", 32'(beep), 32'd1);
    pulse_run();
    check("beep_run_clear", 32'(beep), 32'd0);
    check("beep_run_idle", 32'(phase), 32'd0);
    pulse_run(); step(); step();
    check("beep_done2", 32'(phase), 32'd9);
    repeat (4) tick_pulse();
    check("beep_after4", 32'(beep), 32'd1);
    tick_pulse();
    check("beep_after5", 32'(beep), 32'd0);
    check("beep_still_done", 32'(phase), 32'd9);
    pulse_run();
`else
    tick_pulse();
    check("beep_off", 32'(beep), 32'd0);
    pulse_run();
`endif
    check("end_idle", 32'(phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised wash-program sequencer that replaces the fixed state/run controller pair in the washer top level. It steps through wash, a configurable number of rinse cycles, and a final dry, with per-phase durations in seconds. It supports pause/resume, a door interlock and water-level-scaled fill times. It consumes the pretreated (debounced, single-pulse) buttons and a 1 Hz `tick`, and drives valve/motor/status outputs to the view layer.

## Interface
Parameters:
- TIME_W, 8: width of duration inputs and `remain`.
- LVL_W, 3: width of `level`.
- FILL_T, 2: fill seconds per water-level unit.
- DRAIN_T, 2: drain seconds per drain phase.
- SPIN_T, 3: spin seconds per spin phase.
- BEEP_T, 5: beep seconds after completion (only with WASH_BEEP_EN).

Ports:
- clk  in  1  system clock; only clock.
- resetBtn  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse per second.
- runBtn  in  1  one-cycle pulse; start / pause / resume / acknowledge.
- openBtn  in  1  level; 1 = door open.
- mode  in  3  bit0 wash, bit1 rinse, bit2 dry enable.
- rinses  in  2  rinse cycle count, 0–3 (0 behaves as mode[1]=0).
- level  in  LVL_W  water level; fill time = level*FILL_T, zero-extended to TIME_W, saturating at all-ones.
- wash_time, rinse_time  in  TIME_W  agitation seconds.
- phase  out  4  encoded state (below).
- remain  out  TIME_W  seconds left in current phase.
- rinse_idx  out  2  current rinse cycle, 0-based.
- valve_in, valve_out, motor  out  1  actuator drives.
- running, paused, done, beep  out  1  status.

## Operation
- States (phase code): IDLE 0, FILL_W 1, WASH 2, DRAIN_R 3, SPIN_R 4, FILL_R 5, RINSE 6, DRAIN_D 7, SPIN_D 8, DONE 9, PAUSE 10.
- Nominal order: FILL_W→WASH→(DRAIN_R→SPIN_R→FILL_R→RINSE)×rinses→DRAIN_D→SPIN_D→DONE. Disabled stages are skipped. The dry pair runs only if mode[2]. Latch mode/rinses/durations on start; later input changes are ignored until IDLE.
- IDLE + runBtn + openBtn=0 + mode≠0 → first enabled phase. Otherwise runBtn is ignored.
- On phase entry, `remain` is loaded with the duration. Each running tick: if remain>1, decrement; if remain==1, advance. A duration of 0 advances on the next clk without waiting for a tick.
- Actuators: valve_in in FILL_*; valve_out in DRAIN_* and SPIN_*; motor in WASH, RINSE, SPIN_*. All are 0 in IDLE, PAUSE and DONE.
- Pause: runBtn while running, or openBtn=1 while running, saves the current phase and enters PAUSE. `remain` and `rinse_idx` are held.
- Resume: runBtn in PAUSE with openBtn=0 returns to the saved phase. runBtn with the door open is ignored.
- rinse_idx increments on each RINSE→DRAIN_R loop-back. It is 0 elsewhere on entry to FILL_W/IDLE.
- DONE: done=1. runBtn or resetBtn → IDLE.
- Status: running=1 in any active phase 1–8. paused=1 only in PAUSE.

## Timing
- resetBtn sampled at clk edge: phase=IDLE and all outputs 0 (remain=0, rinse_idx=0). Reset overrides everything, including mid-phase and in PAUSE.
- All outputs are registered. State and actuator changes appear 1 clk after the causing tick or button.
- Same-cycle runBtn and tick while running: pause wins and the tick is discarded (remain unchanged).
- Same-cycle openBtn rise and tick: pause wins.
- runBtn in IDLE with openBtn=1: no start.
- Tick in IDLE/PAUSE/DONE: no effect (except the beep counter in DONE).

## Configuration
- WASH_BEEP_EN defined: on DONE entry, beep=1 for BEEP_T ticks, then 0. The beep counter is loaded on DONE entry. runBtn in DONE clears beep immediately.
- Not defined: beep is constant 0 and no beep counter is built. Everything else is identical.

## Test plan
- Full cycle: mode=3'b111, rinses=2, level=2 (fill 4), wash_time=5, rinse_time=3, ticks every 10 clk → phase sequence 1,2,3,4,5,6,3,4,5,6,7,8,9. DONE reached after 4+5+2×(2+3+4+3)+2+3=38 ticks; rinse_idx reaches 1.
- Pause/door: openBtn=1 in WASH at remain=3 → PAUSE, motor=0, remain holds 3 over 5 ticks. runBtn with door open is ignored. openBtn=0 then runBtn → WASH at remain=3.
- Zero durations: mode=3'b001, level=0, wash_time=0 → FILL_W and WASH each last exactly 1 clk, then DONE with no tick required.
- Simultaneous: runBtn and tick on the same clk in RINSE with remain=1 → PAUSE, remain=1, no advance.
- Reset: resetBtn in SPIN_R → next clk phase=0 and all outputs 0. Start works normally afterwards.
- Beep (WASH_BEEP_EN, BEEP_T=5): DONE → beep=1 for 5 ticks, then 0. runBtn after 2 ticks → beep=0 and phase=IDLE on the next clk.
